uart_tx_core: RTL and testbench

Parametrised UART transmit path for the next-generation UART: write-side FIFO, programmable baud divisor, and runtime-selectable 5–8 data bits, parity and stop bits. Software writes characters from the Wishbone register layer; the block serialises them on stx_pad_o, LSB first. It replaces the fixed-format transmitter inside uart_top and adds FIFO occupancy, overflow and break behaviour.

---
 rtl/uart_pkg.sv | 64 ++++++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    // Baud ticks per serial bit (16x oversampling clock).
    localparam int BIT_TICKS = 16;

    typedef enum logic [1:0] {
        LEN5 = 2'b00,
        LEN6 = 2'b01,
        LEN7 = 2'b10,
        LEN8 = 2'b11
    } char_len_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_e;

    // Per-frame configuration captured when a character is popped.
    // The parity bit is resolved at capture time so the frame is immune
    // to later changes of par_even / par_stick.
    typedef struct packed {
        char_len_e len;
        logic      par_en;
        logic      par_bit;
        logic      two_stop;
    } frame_cfg_t;

    // Clear the bits above the selected character length.
    function automatic logic [7:0] mask_data(input logic [7:0] data, input char_len_e len);
        logic [7:0] m;
        case (len)
            LEN5:    m = 8'h1F;
            LEN6:    m = 8'h3F;
            LEN7:    m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return data & m;
    endfunction

    // Parity over already-masked data; stick parity overrides the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input logic par_even,
                                         input logic par_stick);
        logic p;
        if (par_stick) begin
            p = ~par_even;
        end else if (par_even) begin
            p = ^data;
        end else begin
            p = ~(^data);
        end
        return p;
    endfunction

    // Index of the last data bit for a given length code (4..7).
    function automatic logic [2:0] last_bit_idx(input char_len_e len);
        return {1'b0, len} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x baud tick generator: programmable down-counter, one-cycle pulse.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             baud
);

    logic [DIV_W-1:0] cnt_r;
    logic             baud_r;

    // Reload with divisor-1 at zero so the tick period equals divisor; zero divisor parks the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            baud_r <= 1'b0;
        end else if (divisor == '0) begin
            cnt_r  <= '0;
            baud_r <= 1'b0;
        end else if (cnt_r == '0) begin
            cnt_r  <= divisor - DIV_W'(1);
            baud_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r - DIV_W'(1);
            baud_r <= 1'b0;
        end
    end

    assign baud = baud_r;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: write FIFO, baud generator and frame serialiser.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             fifo_clr,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       char_len,
    input  logic             par_en,
    input  logic             par_even,
    input  logic             par_stick,
    input  logic             two_stop,
    input  logic             brk,
    output logic             stx_pad_o,
    output logic             baud_o,
    output logic             busy,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // FIFO storage and bookkeeping
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             push_s;
    logic             pop_s;

    // Serialiser
    logic             baud_s;
    logic             bit_end_s;
    tx_state_e        state_r;
    tx_state_e        state_nxt_s;
    frame_cfg_t       cfg_r;
    frame_cfg_t       cfg_nxt_s;
    logic [7:0]       head_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic [2:0]       bit_idx_r;
    logic [3:0]       tick_cnt_r;
    logic             line_r;
    logic             line_nxt_s;
    logic             busy_r;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .divisor (divisor),
        .baud    (baud_s)
    );

    assign head_s    = mask_data(mem_r[rd_ptr_r], char_len_e'(char_len));
    assign bit_end_s = baud_s && (tick_cnt_r == 4'(BIT_TICKS - 1));

    // FIFO push / overflow / next occupancy; a flush wins over everything.
    always_comb begin
        push_s    = 1'b0;
        ovf_nxt_s = 1'b0;
        cnt_nxt_s = cnt_r;
        if (fifo_clr) begin
            cnt_nxt_s = '0;
        end else begin
            if (wr_en && (!full_r || pop_s)) begin
                push_s = 1'b1;
            end else begin
                ovf_nxt_s = wr_en;
            end
            cnt_nxt_s = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
        end else begin
            if (fifo_clr) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
            cnt_r   <= cnt_nxt_s;
            full_r  <= (cnt_nxt_s == CNT_W'(FIFO_DEPTH));
            empty_r <= (cnt_nxt_s == '0);
            ovf_r   <= ovf_nxt_s;
        end
    end

    // FIFO storage array; contents need no reset since the count guards reads.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame FSM next state; a pop happens only when a new frame starts.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (baud_s && !empty_r) begin
                    state_nxt_s = START;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == last_bit_idx(cfg_r.len))) begin
                    state_nxt_s = cfg_r.par_en ? PARITY : STOP1;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = STOP1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP1: begin
                if (bit_end_s && cfg_r.two_stop) begin
                    state_nxt_s = STOP2;
                end else if (bit_end_s && !empty_r) begin
                    state_nxt_s = START;
                    pop_s       = 1'b1;
                end else if (bit_end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP1;
                end
            end
            STOP2: begin
                if (bit_end_s && !empty_r) begin
                    state_nxt_s = START;
                    pop_s       = 1'b1;
                end else if (bit_end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP2;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next shift register, captured frame config and line level for the coming cycle.
    always_comb begin
        shift_nxt_s        = shift_r;
        cfg_nxt_s          = cfg_r;
        line_nxt_s         = 1'b1;
        if (pop_s) begin
            shift_nxt_s        = head_s;
            cfg_nxt_s.len      = char_len_e'(char_len);
            cfg_nxt_s.par_en   = par_en;
            cfg_nxt_s.par_bit  = calc_parity(head_s, par_even, par_stick);
            cfg_nxt_s.two_stop = two_stop;
        end else if ((state_r == DATA) && bit_end_s) begin
            shift_nxt_s = {1'b0, shift_r[7:1]};
        end else begin
            shift_nxt_s = shift_r;
        end
        case (state_nxt_s)
            IDLE:    line_nxt_s = 1'b1;
            START:   line_nxt_s = 1'b0;
            DATA:    line_nxt_s = shift_nxt_s[0];
            PARITY:  line_nxt_s = cfg_r.par_bit;
            STOP1:   line_nxt_s = 1'b1;
            STOP2:   line_nxt_s = 1'b1;
            default: line_nxt_s = 1'b1;
        endcase
    end

    // Serialiser datapath: bit timing, data shifting and registered line / busy.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cfg_r      <= '0;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            tick_cnt_r <= 4'd0;
            line_r     <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            cfg_r   <= cfg_nxt_s;
            shift_r <= shift_nxt_s;
            if (pop_s) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == DATA) && bit_end_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (state_r == IDLE) begin
                tick_cnt_r <= 4'd0;
            end else if (baud_s) begin
                tick_cnt_r <= tick_cnt_r + 4'd1;
            end
            line_r <= line_nxt_s;
            busy_r <= (state_nxt_s != IDLE);
        end
    end

    // Break overrides the line asynchronously to the frame timing.
    assign stx_pad_o  = line_r & ~brk;
    assign baud_o     = baud_s;
    assign busy       = busy_r;
    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;
    assign fifo_cnt   = cnt_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frame vectors plus FIFO/break/reset corner cases.
module tb_uart_tx_core;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int CNT_W      = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             fifo_clr;
    logic [DIV_W-1:0] divisor;
    logic [1:0]       char_len;
    logic             par_en;
    logic             par_even;
    logic             par_stick;
    logic             two_stop;
    logic             brk;
    logic             stx;
    logic             baud;
    logic             busy;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_core #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_clr   (fifo_clr),
        .divisor    (divisor),
        .char_len   (char_len),
        .par_en     (par_en),
        .par_even   (par_even),
        .par_stick  (par_stick),
        .two_stop   (two_stop),
        .brk        (brk),
        .stx_pad_o  (stx),
        .baud_o     (baud),
        .busy       (busy),
        .fifo_full  (full),
        .fifo_empty (empty),
        .fifo_cnt   (cnt),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  len;
        logic        pen;
        logic        peven;
        logic        pstick;
        logic        two;
        int          dv;
        logic [11:0] bits;   // expected line level of bit i (start first)
        int          n;      // number of bits in the frame
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_char(input logic [7:0] d);
        @(negedge clk);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Step negedges until the line drops (start bit), bounded.
    task automatic wait_start(input string name, output int waited);
        waited = 0;
        while (stx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s_start_seen", name), 32'(stx === 1'b0), 32'd1);
    endtask

    // Called at the first negedge of a start bit; samples each bit mid-way
    // and leaves the bench at the first negedge after the frame.
    task automatic check_frame(input string name, input logic [11:0] bits, input int n,
                               input int dv, input bit last);
        int pos = 0;
        int tgt;
        for (int b = 0; b < n; b++) begin
            tgt = b * 16 * dv + 8 * dv;
            repeat (tgt - pos) @(negedge clk);
            pos = tgt;
            check($sformatf("%s_bit%0d", name, b), 32'(stx), 32'(bits[b]));
        end
        repeat (n * 16 * dv - 1 - pos) @(negedge clk);
        check($sformatf("%s_busy_end", name), 32'(busy), 32'd1);
        @(negedge clk);
        if (last) begin
            check($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
            check($sformatf("%s_idle_line", name), 32'(stx), 32'd1);
        end else begin
            check($sformatf("%s_next_start", name), 32'(stx), 32'd0);
            check($sformatf("%s_next_busy", name), 32'(busy), 32'd1);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [7:0] d;
        wr_en = 1'b0; wr_data = 8'h00; fifo_clr = 1'b0; divisor = 16'd1;
        char_len = 2'b11; par_en = 1'b0; par_even = 1'b0; par_stick = 1'b0;
        two_stop = 1'b0; brk = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stx", 32'(stx), 32'd1);
        check("rst_baud", 32'(baud), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        //          data   len    pen   peven pstick two   dv  bits      n
        vecs[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 12'h2AA, 10}; // 8N1
        vecs[1] = '{8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 2, 12'h682, 11}; // 7E2
        vecs[2] = '{8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 12'h0BE, 8};  // 5O1
        vecs[3] = '{8'hFF, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 12'h0FE, 8};  // 5, stick -> 1
        vecs[4] = '{8'hEC, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1, 12'h1D8, 9};  // 6E1, top bits ignored
        vecs[5] = '{8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 12'h74A, 11}; // 8O1

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            divisor   = 16'(vecs[i].dv);
            char_len  = vecs[i].len;
            par_en    = vecs[i].pen;
            par_even  = vecs[i].peven;
            par_stick = vecs[i].pstick;
            two_stop  = vecs[i].two;
            write_char(vecs[i].data);
            wait_start($sformatf("vec%0d", i), w);
            if (vecs[i].dv == 1) begin
                check($sformatf("vec%0d_latency", i), 32'(w), 32'd1);
            end
            check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].n, vecs[i].dv, 1'b1);
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'd1);
        end

        // FIFO fill with the baud generator stopped, then overflow
        divisor = 16'd0; char_len = 2'b11; par_en = 1'b0; par_stick = 1'b0; two_stop = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h30 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("fill_cnt", 32'(cnt), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        check("fill_ovf_quiet", 32'(ovf), 32'd0);
        check("fill_no_tx", 32'(busy), 32'd0);
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_cnt", 32'(cnt), 32'd16);
        @(negedge clk);
        check("ovf_one_cycle", 32'(ovf), 32'd0);
        divisor = 16'd1;
        wait_start("b2b", w);
        for (int f = 0; f < 16; f++) begin
            d = 8'h30 + 8'(f);
            check_frame($sformatf("b2b%0d", f), {2'b00, 1'b1, d, 1'b0}, 10, 1, (f == 15));
        end
        check("b2b_empty", 32'(empty), 32'd1);
        check("b2b_cnt", 32'(cnt), 32'd0);

        // Break over the data bits of 0xA5, released in the stop bit
        repeat (5) @(negedge clk);
        write_char(8'hA5);
        wait_start("brk", w);
        write_char(8'h3C);                  // now at start + 2
        repeat (16) @(negedge clk);         // start + 18, inside data bit 0
        brk = 1'b1;
        repeat (6) @(negedge clk);          // start + 24
        for (int b = 1; b <= 8; b++) begin
            check($sformatf("brk_data%0d", b), 32'(stx), 32'd0);
            repeat (16) @(negedge clk);
        end                                  // start + 152, stop bit
        check("brk_busy", 32'(busy), 32'd1);
        check("brk_fifo_kept", 32'(cnt), 32'd1);
        brk = 1'b0;
        @(negedge clk);
        check("brk_release_line", 32'(stx), 32'd1);
        repeat (7) @(negedge clk);          // start + 160: next frame
        check_frame("brk_next", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1, 1'b1);

        // Reset in the middle of a frame
        write_char(8'h00);
        wait_start("rstmid", w);
        write_char(8'h11);
        write_char(8'h22);                  // start + 4
        repeat (26) @(negedge clk);         // start + 30, data bit 0
        check("rstmid_pre_line", 32'(stx), 32'd0);
        check("rstmid_pre_cnt", 32'(cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstmid_line", 32'(stx), 32'd1);
        check("rstmid_cnt", 32'(cnt), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_stays_idle", 32'(stx), 32'd1);
        check("rstmid_stays_notbusy", 32'(busy), 32'd0);

        // Flush with a same-cycle write, then refill from pointer zero
        divisor = 16'd0;
        repeat (2) @(negedge clk);
        write_char(8'h12);
        write_char(8'h34);
        check("clr_pre_cnt", 32'(cnt), 32'd2);
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h56; fifo_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; fifo_clr = 1'b0;
        check("clr_cnt", 32'(cnt), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        write_char(8'h9A);
        check("clr_refill_cnt", 32'(cnt), 32'd1);
        divisor = 16'd1;
        wait_start("clr", w);
        check_frame("clr_frame", {2'b00, 1'b1, 8'h9A, 1'b0}, 10, 1, 1'b1);
        check("clr_final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
